// File: rtl/fir_pkg.sv
// Shared sample and accumulator definitions for the FIR stage and its requantizer.
`timescale 1ns/1ps
package fir_pkg;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    localparam sample_t SAT_MAX = 16'sh7FFF;
    localparam sample_t SAT_MIN = 16'sh8000;

    // Staged sample: data plus a flag that saturation was applied.
    typedef struct packed {
        logic    sat;
        sample_t data;
    } rq_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head so the output word holds
// its last value while the FIFO is empty. Level is tracked separately from the
// pointers. A push into a full FIFO is accepted only when a pop happens in the
// same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q, rptr_inc;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign rptr_inc = rptr_q + AW'(1);
    assign dout     = head_q;
    assign level    = level_q;

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wptr_q] <= din;
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_inc;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            // Head follows the next stored word on a pop; when the popped word
            // was the last one, the same-cycle push (if any) becomes the head.
            if (do_pop) begin
                if (level_q > (AW+1)'(1)) head_q <= mem_q[rptr_inc];
                else if (do_push)         head_q <= din;
            end else if (do_push && empty) begin
                head_q <= din;
            end
        end
    end
endmodule

// File: rtl/fir_out_requant.sv
// Requantizes the 32-bit FIR accumulator to 16 bits (round-half-up, saturate),
// optionally decimates, stages one register and buffers into an output FIFO.
`timescale 1ns/1ps
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int SHIFT = 16,  // 1..31
    parameter int DEC_M = 1,   // 1..16
    parameter int DEPTH = 8    // power of two, 2..32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ACC_W-1:0]         y_in,
    input  logic                     in_valid,
    input  logic                     clr,
    output logic [SAMPLE_W-1:0]      s_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat,
    output logic                     ovf
);
    // Work in ACC_W+1 bits so adding the rounding constant can never wrap.
    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_W:0] R_MAX = {{(ACC_W+1-SAMPLE_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W:0] R_MIN = {{(ACC_W+1-SAMPLE_W){1'b1}}, SAT_MIN};

    logic signed [ACC_W:0] sum, r;
    rq_t                   rq;
    logic                  accept;
    logic [3:0]            phase_q, phase_d;
    logic                  q_valid_q;
    sample_t               q_data_q;
    logic                  sat_q, ovf_q;
    logic                  fifo_full, fifo_empty, pop;

    assign sum = $signed({y_in[ACC_W-1], y_in}) + RND;
    assign r   = sum >>> SHIFT;

    // Clamp the rounded value into the 16-bit range.
    always_comb begin
        rq.sat  = 1'b0;
        rq.data = r[SAMPLE_W-1:0];
        if (r > R_MAX) begin
            rq.sat  = 1'b1;
            rq.data = SAT_MAX;
        end else if (r < R_MIN) begin
            rq.sat  = 1'b1;
            rq.data = SAT_MIN;
        end
    end

    // Decimation phase advances on every input sample and wraps at DEC_M.
    always_comb begin
        phase_d = phase_q;
        if (in_valid) phase_d = (phase_q == 4'(DEC_M-1)) ? 4'd0 : phase_q + 4'd1;
    end

    assign accept = in_valid && (phase_q == 4'd0);

    // Stage 1: capture the accepted sample and track saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= '0;
            q_valid_q <= 1'b0;
            q_data_q  <= '0;
            sat_q     <= 1'b0;
        end else if (clr) begin
            phase_q   <= '0;
            q_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            q_valid_q <= accept;
            if (accept)          q_data_q <= rq.data;
            if (accept && rq.sat) sat_q   <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Overflow is flagged only when a push is actually lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  ovf_q <= 1'b0;
        else if (clr)                              ovf_q <= 1'b0;
        else if (q_valid_q && fifo_full && !pop)   ovf_q <= 1'b1;
    end

    assign sat = sat_q;
    assign ovf = ovf_q;

    sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (q_valid_q),
        .pop   (pop),
        .din   (q_data_q),
        .dout  (s_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );
endmodule
